// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte/word helpers used by the
// sequencer and its round datapath.
package aes_pkg;
   localparam int NR = 10;
   localparam int W  = 128;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RED_POLY  = 8'h1B;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction
endpackage

// File: rtl/aes_round_fn.sv
// One AES round, purely combinational: SubBytes, ShiftRows, MixColumns
// (skipped when final_i) and AddRoundKey. Byte i of the block is row i%4, column i/4.
module aes_round_fn
   import aes_pkg::*;
(
   input  logic [W-1:0] state_i,
   input  logic [W-1:0] rkey_i,
   input  logic         final_i,
   output logic [W-1:0] state_o
);
   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];
   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      a0 = 8'h00;
      a1 = 8'h00;
      a2 = 8'h00;
      a3 = 8'h00;
      state_o = '0;
      for (int i = 0; i < 16; i++) sb[i] = sbox(state_i[127-8*i -: 8]);
      // Row r rotates left by r columns.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c+r] = sb[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      for (int i = 0; i < 16; i++)
         state_o[127-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rkey_i[127-8*i -: 8];
   end
endmodule

// File: rtl/aes_encry_seq.sv
// Iterative AES-128 encryptor, one round per clock; out_valid 11 cycles after accept, held until out_ready.
// No input accepted while busy or presenting a result; AES_ABORT_EN adds an abort input that drops back to IDLE.
module aes_encry_seq
   import aes_pkg::*;
(
`ifdef AES_ABORT_EN
   input  logic         abort,
`endif
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] i_block,
   input  logic [W-1:0] key,
   output logic [W-1:0] o_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic [3:0]   round
);
   fsm_e         fsm_q;
   logic [W-1:0] blk_q, key_q, o_block_q;
   logic [W-1:0] blk_d, key_d;
   logic [7:0]   rcon_q;
   logic [3:0]   round_q;
   logic         in_ready_q, out_valid_q, busy_q;
   logic [31:0]  ktmp, n0, n1, n2, n3;
   logic         last_rnd, abort_hit;

`ifdef AES_ABORT_EN
   assign abort_hit = abort && (fsm_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign last_rnd = (round_q == 4'(NR));

   // Next round key derived from the current one on the fly.
   always_comb begin
      ktmp  = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h000000};
      n0    = key_q[127:96] ^ ktmp;
      n1    = key_q[95:64]  ^ n0;
      n2    = key_q[63:32]  ^ n1;
      n3    = key_q[31:0]   ^ n2;
      key_d = {n0, n1, n2, n3};
   end

   aes_round_fn u_round (
      .state_i (blk_q),
      .rkey_i  (key_d),
      .final_i (last_rnd),
      .state_o (blk_d)
   );

   always_ff @(posedge clk) begin
      if (rst || abort_hit) begin
         fsm_q       <= IDLE;
         blk_q       <= '0;
         key_q       <= '0;
         o_block_q   <= '0;
         rcon_q      <= RCON_INIT;
         round_q     <= 4'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  blk_q      <= i_block ^ key;
                  key_q      <= key;
                  rcon_q     <= RCON_INIT;
                  round_q    <= 4'd1;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  fsm_q      <= ROUND;
               end
            end
            ROUND: begin
               blk_q  <= blk_d;
               key_q  <= key_d;
               rcon_q <= xtime(rcon_q);
               if (last_rnd) begin
                  o_block_q   <= blk_d;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  round_q     <= 4'd0;
                  fsm_q       <= DONE;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            DONE: begin
               // in_ready returns only after the handoff edge.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  fsm_q       <= IDLE;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign o_block   = o_block_q;
   assign busy      = busy_q;
   assign round     = round_q;
endmodule

// File: tb/tb_aes_encry_seq.sv
// Bench for aes_encry_seq: known-answer table, handshake corner sequences and
// random blocks checked against a byte-matrix AES model with a derived S-box.
module tb_aes_encry_seq;
   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [127:0] i_block, key;
   logic [127:0] o_block;
   logic         in_ready, out_valid, busy;
   logic [3:0]   round;
`ifdef AES_ABORT_EN
   logic         abort = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] sbox_m [256];

   aes_encry_seq dut (
`ifdef AES_ABORT_EN
      .abort     (abort),
`endif
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .i_block   (i_block),
      .key       (key),
      .o_block   (o_block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .round     (round)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [127:0] pt;
      logic [127:0] k;
      logic [127:0] ct;
   } vec_t;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0]  inv;
      logic [15:0] bb;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         bb = {inv, inv};
         sbox_m[x] = inv ^ 8'(bb >> 7) ^ 8'(bb >> 6) ^ 8'(bb >> 5) ^ 8'(bb >> 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc = 8'h01;
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   coef [4];
      logic [127:0] ct;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_m[s[r][(c+r)%4]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               if (rnd < 10) begin
                  s[r][c] = 8'h00;
                  for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gmul(coef[(j-r+4)%4], t[j][c]);
               end else begin
                  s[r][c] = t[r][c];
               end
               s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            ct[127-8*(4*c+r) -: 8] = s[r][c];
      return ct;
   endfunction

   // Called at a falling edge; returns at the falling edge of round 1.
   task automatic drive_accept(input logic [127:0] pt, input logic [127:0] k);
      i_block  = pt;
      key      = k;
      in_valid = 1'b1;
      chk("accept_in_ready", 128'(in_ready), 128'd1);
      @(negedge clk);
      in_valid = 1'b0;
      i_block  = {$urandom, $urandom, $urandom, $urandom};
      key      = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Latency counted from the accept cycle (round 1 is cycle 1).
   task automatic wait_out(output logic [127:0] ct, output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         chk("round_idx", 128'(round), (lat <= 10) ? 128'(lat) : 128'd0);
         chk("busy_in_round", {126'd0, busy, in_ready}, 128'd2);
         @(negedge clk);
         lat++;
      end
      chk("out_valid_seen", 128'(out_valid), 128'd1);
      chk("round_done", 128'(round), 128'd0);
      ct = o_block;
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("handoff_out_valid", 128'(out_valid), 128'd0);
      chk("handoff_in_ready", 128'(in_ready), 128'd1);
   endtask

   vec_t         vt [3];
   logic [127:0] ct, pt, kk;
   int           lat;

   initial begin
      vt[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
      vt[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      build_sbox();

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; i_block = '0; key = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_round", 128'(round), 128'd0);
      chk("rst_o_block", o_block, 128'd0);

      for (int i = 0; i < 3; i++) begin
         drive_accept(vt[i].pt, vt[i].k);
         wait_out(ct, lat);
         chk("kat_ct", ct, vt[i].ct);
         chk("kat_latency", 128'(lat), 128'd11);
         handoff();
      end

      // Downstream stall for 20 cycles.
      drive_accept(vt[0].pt, vt[0].k);
      wait_out(ct, lat);
      for (int i = 0; i < 20; i++) begin
         chk("stall_o_block", o_block, vt[0].ct);
         chk("stall_valid_ready", {126'd0, out_valid, in_ready}, 128'd2);
         @(negedge clk);
      end
      handoff();

      // New pair held on the input throughout the first transaction.
      drive_accept(vt[0].pt, vt[0].k);
      in_valid = 1'b1; i_block = vt[1].pt; key = vt[1].k;
      wait_out(ct, lat);
      chk("busy_first_ct", ct, vt[0].ct);
      handoff();
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_second_accepted", 128'(busy), 128'd1);
      wait_out(ct, lat);
      chk("busy_second_ct", ct, vt[1].ct);
      chk("busy_second_latency", 128'(lat), 128'd11);
      handoff();

      // Synchronous reset at round 5.
      drive_accept(vt[0].pt, vt[0].k);
      repeat (4) @(negedge clk);
      chk("pre_reset_round", 128'(round), 128'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_idle", {125'd0, in_ready, out_valid, busy}, 128'd4);
      chk("midrst_round", 128'(round), 128'd0);
      for (int i = 0; i < 12; i++) begin
         chk("midrst_no_valid", 128'(out_valid), 128'd0);
         @(negedge clk);
      end
      drive_accept(vt[0].pt, vt[0].k);
      wait_out(ct, lat);
      chk("post_reset_ct", ct, vt[0].ct);
      handoff();

`ifdef AES_ABORT_EN
      drive_accept(vt[1].pt, vt[1].k);
      repeat (2) @(negedge clk);
      chk("pre_abort_round", 128'(round), 128'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {125'd0, in_ready, out_valid, busy}, 128'd4);
      chk("abort_round", 128'(round), 128'd0);
      for (int i = 0; i < 12; i++) begin
         chk("abort_no_valid", 128'(out_valid), 128'd0);
         @(negedge clk);
      end
      drive_accept(vt[1].pt, vt[1].k);
      wait_out(ct, lat);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_done_valid", 128'(out_valid), 128'd0);
      chk("abort_done_ready", 128'(in_ready), 128'd1);
`endif

      // Random pairs against the reference model, random downstream delay.
      for (int n = 0; n < 20; n++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         kk = {$urandom, $urandom, $urandom, $urandom};
         drive_accept(pt, kk);
         wait_out(ct, lat);
         chk("rand_latency", 128'(lat), 128'd11);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("rand_ct", o_block, aes_ref(pt, kk));
         handoff();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
